// File: rtl/softmax_exp_sequencer.sv
// rtl/softmax_exp_sequencer.sv - softmax row buffer and exp-unit sequencer; optional max subtraction via SOFTMAX_MAX_SUB_EN
module softmax_exp_sequencer #(
    parameter int Q           = 26,
    parameter int W           = 32,
    parameter int DEPTH       = 64,
    parameter int SUM_W       = W + $clog2(DEPTH),
    parameter int EXP_TIMEOUT = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             exp_start,
    output logic [W-1:0]     exp_x_q,
    input  logic             exp_busy,
    input  logic             exp_done,
    input  logic [W-1:0]     exp_y_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic [SUM_W-1:0] sum_q,
    output logic             sum_valid,
    output logic             err_timeout,
    output logic             err_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(EXP_TIMEOUT + 1);

    // The data format needs at least one integer/sign bit above the fraction.
    if (Q < 1 || Q >= W) begin : g_bad_q_format
        $error("softmax_exp_sequencer: Q must lie in 1..W-1");
    end

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_DRAIN  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_STREAM = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [W-1:0]       mem [DEPTH];
    logic [CW-1:0]      cnt;
    logic [AW-1:0]      idx;
    logic [AW-1:0]      ridx;
    logic [TW-1:0]      tcnt;
    logic [SUM_W-1:0]   sum_r;

    logic               in_fire;
    logic               out_fire;
    logic               load_full;
    logic               idx_last;
    logic               ridx_last;
    logic               tmo;
    logic               step;
    logic [W-1:0]       clamp_y;
    logic [W-1:0]       step_y;
    logic [W-1:0]       elem;
    logic [W-1:0]       arg;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign load_full = (cnt == CW'(DEPTH - 1));
    assign idx_last  = ({1'b0, idx} == (cnt - CW'(1)));
    assign ridx_last = ({1'b0, ridx} == (cnt - CW'(1)));
    assign tmo       = (tcnt == TW'(EXP_TIMEOUT - 1));
    assign step      = (state == S_WAIT) && (exp_done || tmo);
    assign clamp_y   = exp_y_q[W-1] ? '0 : exp_y_q;
    assign step_y    = exp_done ? clamp_y : '0;
    assign elem      = mem[idx];
    assign sum_q     = sum_r;
    assign out_last  = out_valid & ridx_last;

`ifdef SOFTMAX_MAX_SUB_EN
    logic [W-1:0]       max_r;
    logic [W:0]         diff;

    // Difference in W+1 bits, clamped back into the signed W-bit range
    always_comb begin
        diff = {elem[W-1], elem} - {max_r[W-1], max_r};
        if (diff[W] != diff[W-1]) begin
            arg = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            arg = diff[W-1:0];
        end
    end

    // Row maximum: first beat loads unconditionally, later beats on signed greater-than
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_r <= '0;
        end else if (state == S_LOAD && in_fire) begin
            if (cnt == '0 || $signed(in_data) > $signed(max_r)) begin
                max_r <= in_data;
            end
        end else if (state == S_STREAM && out_fire && ridx_last) begin
            max_r <= '0;
        end
    end
`else
    // Without max tracking the stored score goes to the exp unit unmodified
    always_comb begin
        arg = elem;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_LOAD: begin
                if (in_fire) begin
                    if (in_last) begin
                        next_state = S_ISSUE;
                    end else if (load_full) begin
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (in_fire && in_last) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!exp_busy) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (step) begin
                    next_state = idx_last ? S_STREAM : S_ISSUE;
                end
            end
            S_STREAM: begin
                if (out_fire && ridx_last) begin
                    next_state = S_LOAD;
                end
            end
            default: next_state = S_LOAD;
        endcase
    end

    // State-decoded outputs; in_ready is held low while reset is applied
    always_comb begin
        in_ready  = 1'b0;
        exp_start = 1'b0;
        exp_x_q   = '0;
        sum_valid = 1'b0;
        case (state)
            S_LOAD, S_DRAIN: in_ready = rst_n;
            S_ISSUE: begin
                exp_start = !exp_busy;
                exp_x_q   = arg;
            end
            S_WAIT:   exp_x_q   = arg;
            S_STREAM: sum_valid = 1'b1;
            default: ;
        endcase
    end

    // Row buffer: scores while loading, clamped exp results while waiting
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_fire) begin
            mem[cnt[AW-1:0]] <= in_data;
        end else if (step) begin
            mem[idx] <= step_y;
        end
    end

    // Row bookkeeping: element count, issue index, timeout, sum and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            tcnt        <= '0;
            sum_r       <= '0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    idx <= '0;
                    if (in_fire) begin
                        cnt <= cnt + CW'(1);
                        if (load_full && !in_last) begin
                            err_ovf <= 1'b1;
                        end
                    end
                end
                S_DRAIN: idx <= '0;
                S_ISSUE: tcnt <= '0;
                S_WAIT: begin
                    if (step) begin
                        sum_r <= sum_r + {{(SUM_W-W){1'b0}}, step_y};
                        idx   <= idx + AW'(1);
                        if (!exp_done) begin
                            err_timeout <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_STREAM: begin
                    if (out_fire && ridx_last) begin
                        cnt   <= '0;
                        sum_r <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output stream: registered buffer read, next element prefetched on each handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ridx      <= '0;
        end else if (state == S_STREAM) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                out_data  <= mem[ridx];
            end else if (out_ready) begin
                if (ridx_last) begin
                    out_valid <= 1'b0;
                    ridx      <= '0;
                end else begin
                    ridx     <= ridx + AW'(1);
                    out_data <= mem[ridx + AW'(1)];
                end
            end
        end
    end

endmodule

// File: tb/tb_softmax_exp_sequencer.sv
// tb/tb_softmax_exp_sequencer.sv - scoreboard bench for softmax_exp_sequencer (follows SOFTMAX_MAX_SUB_EN)
module tb_softmax_exp_sequencer;

    localparam int W     = 32;
    localparam int DEPTH = 64;
    localparam int SUM_W = 38;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             exp_start;
    logic [W-1:0]     exp_x_q;
    logic             exp_busy;
    logic             exp_done;
    logic [W-1:0]     exp_y_q;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_last;
    logic [SUM_W-1:0] sum_q;
    logic             sum_valid;
    logic             err_timeout;
    logic             err_ovf;

    softmax_exp_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .exp_start(exp_start), .exp_x_q(exp_x_q), .exp_busy(exp_busy),
        .exp_done(exp_done), .exp_y_q(exp_y_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sum_q(sum_q), .sum_valid(sum_valid), .err_timeout(err_timeout), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]     exp_arg_q [$];
    logic [W:0]       exp_out_q [$];
    logic [SUM_W-1:0] exp_sum_q [$];

    int lat      = 5;
    int n_starts = 0;
    int drop_at  = -1;
    bit neg_next = 1'b0;
    bit bp_mode  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Hand-tabulated Q5.26 exp values for the arguments used below
    function automatic logic [W-1:0] resp(input logic [W-1:0] x);
        case (x)
            32'h00000000: resp = 32'h04000000;
            32'hFC000000: resp = 32'h0178B56D;
            32'h04000000: resp = 32'h0ADF8546;
            32'h08000000: resp = 32'h1D8E64B8;
            32'hF8000000: resp = 32'h008A95F2;
            32'h80000000: resp = 32'h00000000;
            default:      resp = x[W-1] ? 32'h0 : 32'h7FFFFFFF;
        endcase
    endfunction

    task automatic expect_elem(input logic [W-1:0] a, input logic [W-1:0] y, input logic l);
        exp_arg_q.push_back(a);
        exp_out_q.push_back({l, y});
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int  guard = 0;
        logic hs = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!hs && guard < 2000) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (!hs) begin
            bad++;
            $display("FAIL in_handshake: in_ready=0 for %0d cycles, required 1", guard);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_out_q.size() != 0 || exp_arg_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL row_complete: %0d outputs still pending after %0d cycles, required 0", exp_out_q.size(), n);
        end
        check("in_ready_after_row", in_ready, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_exp_start"}, exp_start, 0);
        check({tag, "_exp_x_q"},   exp_x_q,   0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_sum_q"},     sum_q,     0);
        check({tag, "_sum_valid"}, sum_valid, 0);
        check({tag, "_err_to"},    err_timeout, 0);
        check({tag, "_err_ovf"},   err_ovf,   0);
    endtask

    // Behavioural exp unit: argument scoreboard, latency, dropped request, negative result
    initial begin : responder
        logic         st;
        logic [W-1:0] sarg;
        logic [W-1:0] held = '0;
        int           cd   = 0;
        bit           pend = 1'b0;
        bit           negy = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_y_q  = '0;
        forever begin
            @(negedge clk);
            st   = exp_start;
            sarg = exp_x_q;
            if (st) begin
                if (exp_arg_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL exp_start_extra: got start with arg %0h, required none", sarg);
                end else begin
                    check("exp_x_q", sarg, exp_arg_q.pop_front());
                end
            end else if (pend && rst_n) begin
                check("exp_x_hold", exp_x_q, held);
            end
            @(posedge clk);
            #1;
            exp_done = 1'b0;
            exp_y_q  = '0;
            if (!rst_n) begin
                pend     = 1'b0;
                exp_busy = 1'b0;
                continue;
            end
            if (pend) begin
                if (cd == 0) begin
                    exp_done = 1'b1;
                    exp_y_q  = negy ? 32'hFFFFFFF0 : resp(held);
                    pend     = 1'b0;
                    exp_busy = 1'b0;
                end else begin
                    cd--;
                end
            end else if (st) begin
                n_starts++;
                if (n_starts != drop_at) begin
                    pend     = 1'b1;
                    exp_busy = 1'b1;
                    cd       = lat - 1;
                    held     = sarg;
                    negy     = neg_next;
                    neg_next = 1'b0;
                end
            end
        end
    end

    // Downstream ready: steady or toggling every cycle
    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? !out_ready : 1'b1;
        end
    end

    // Output monitor: pops expected beats on handshakes, checks hold and sum stability
    initial begin : out_mon
        logic [W-1:0] pd = '0;
        logic         pl = 1'b0;
        bit           ph = 1'b0;
        logic [W:0]   e;
        forever begin
            @(negedge clk);
            if (ph && rst_n) begin
                check("hold_valid", out_valid, 1);
                check("hold_data",  out_data,  pd);
                check("hold_last",  out_last,  pl);
            end
            if (sum_valid && exp_sum_q.size() > 0) begin
                check("sum_q", sum_q, exp_sum_q[0]);
            end
            if (out_valid && out_ready) begin
                check("in_ready_excl", in_ready, 0);
                if (exp_out_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_extra: got beat %0h, required none", out_data);
                end else begin
                    e = exp_out_q.pop_front();
                    check("out_data",  out_data,  e[W-1:0]);
                    check("out_last",  out_last,  e[W]);
                    check("sum_valid", sum_valid, 1);
                    if (e[W] && exp_sum_q.size() > 0) begin
                        void'(exp_sum_q.pop_front());
                    end
                end
            end
            ph = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
        end
    end

    initial begin : main
        int s0;
        int guard;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("in_ready_release", in_ready, 1);
        @(posedge clk);
        #1;

        // Row {1.0, 2.0, 2.0}
        lat = 5;
`ifdef SOFTMAX_MAX_SUB_EN
        expect_elem(32'hFC000000, 32'h0178B56D, 1'b0);
        expect_elem(32'h00000000, 32'h04000000, 1'b0);
        expect_elem(32'h00000000, 32'h04000000, 1'b1);
        exp_sum_q.push_back(38'h0978B56D);
`else
        expect_elem(32'h04000000, 32'h0ADF8546, 1'b0);
        expect_elem(32'h08000000, 32'h1D8E64B8, 1'b0);
        expect_elem(32'h08000000, 32'h1D8E64B8, 1'b1);
        exp_sum_q.push_back(38'h45FC4EB6);
`endif
        send_beat(32'h04000000, 1'b0);
        send_beat(32'h08000000, 1'b0);
        send_beat(32'h08000000, 1'b1);
        check("first_start_latency", exp_start, 1);
        wait_idle(400);

        // Backpressure, row {0, -1, -2, 0}: max is 0 so both builds agree
        lat     = 2;
        bp_mode = 1'b1;
        expect_elem(32'h00000000, 32'h04000000, 1'b0);
        expect_elem(32'hFC000000, 32'h0178B56D, 1'b0);
        expect_elem(32'hF8000000, 32'h008A95F2, 1'b0);
        expect_elem(32'h00000000, 32'h04000000, 1'b1);
        exp_sum_q.push_back(38'h0A034B5F);
        send_beat(32'h00000000, 1'b0);
        send_beat(32'hFC000000, 1'b0);
        send_beat(32'hF8000000, 1'b0);
        send_beat(32'h00000000, 1'b1);
        wait_idle(400);
        bp_mode = 1'b0;

        // Extreme scores {-32.0, +32.0): saturating subtraction
        lat = 3;
`ifdef SOFTMAX_MAX_SUB_EN
        expect_elem(32'h80000000, 32'h00000000, 1'b0);
        expect_elem(32'h00000000, 32'h04000000, 1'b1);
        exp_sum_q.push_back(38'h04000000);
`else
        expect_elem(32'h80000000, 32'h00000000, 1'b0);
        expect_elem(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
        exp_sum_q.push_back(38'h7FFFFFFF);
`endif
        send_beat(32'h80000000, 1'b0);
        send_beat(32'h7FFFFFFF, 1'b1);
        wait_idle(400);

        // All-negative row; first exp result comes back negative
        neg_next = 1'b1;
`ifdef SOFTMAX_MAX_SUB_EN
        expect_elem(32'h00000000, 32'h00000000, 1'b0);
        expect_elem(32'h00000000, 32'h04000000, 1'b1);
        exp_sum_q.push_back(38'h04000000);
`else
        expect_elem(32'hFC000000, 32'h00000000, 1'b0);
        expect_elem(32'hFC000000, 32'h0178B56D, 1'b1);
        exp_sum_q.push_back(38'h0178B56D);
`endif
        send_beat(32'hFC000000, 1'b0);
        send_beat(32'hFC000000, 1'b1);
        wait_idle(400);

        // Timeout on element 1 of a 4-row
        lat     = 4;
        drop_at = n_starts + 2;
        expect_elem(32'h0, 32'h04000000, 1'b0);
        expect_elem(32'h0, 32'h00000000, 1'b0);
        expect_elem(32'h0, 32'h04000000, 1'b0);
        expect_elem(32'h0, 32'h04000000, 1'b1);
        exp_sum_q.push_back(38'h0C000000);
        for (int i = 0; i < 4; i++) send_beat(32'h0, i == 3);
        wait_idle(900);
        drop_at = -1;
        check("err_timeout_set", err_timeout, 1);
        check("err_ovf_clear",   err_ovf,     0);

        // Overflow: DEPTH+3 beats, last flag only on the final one
        lat = 2;
        s0  = n_starts;
        for (int i = 0; i < DEPTH; i++) expect_elem(32'h0, 32'h04000000, i == DEPTH - 1);
        exp_sum_q.push_back(38'h1_0000_0000);
        for (int i = 0; i < DEPTH + 3; i++) send_beat(32'h0, i == DEPTH + 2);
        wait_idle(2000);
        check("err_ovf_set", err_ovf, 1);
        check("ovf_start_count", n_starts - s0, DEPTH);

        // Reset while waiting on the exp unit, then a clean row
        lat = 20;
        s0  = n_starts;
        expect_elem(32'h0, 32'h04000000, 1'b0);
        expect_elem(32'h0, 32'h04000000, 1'b0);
        expect_elem(32'h0, 32'h04000000, 1'b1);
        exp_sum_q.push_back(38'h0C000000);
        for (int i = 0; i < 3; i++) send_beat(32'h0, i == 2);
        guard = 0;
        while (n_starts == s0 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("start_before_reset", n_starts - s0, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrow_reset");
        exp_arg_q.delete();
        exp_out_q.delete();
        exp_sum_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat = 3;
`ifdef SOFTMAX_MAX_SUB_EN
        expect_elem(32'hFC000000, 32'h0178B56D, 1'b0);
        expect_elem(32'h00000000, 32'h04000000, 1'b1);
        exp_sum_q.push_back(38'h0578B56D);
`else
        expect_elem(32'h04000000, 32'h0ADF8546, 1'b0);
        expect_elem(32'h08000000, 32'h1D8E64B8, 1'b1);
        exp_sum_q.push_back(38'h286DE9FE);
`endif
        send_beat(32'h04000000, 1'b0);
        send_beat(32'h08000000, 1'b1);
        wait_idle(400);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/softmax_exp_sequencer.md
# softmax_exp_sequencer

Row-level initiator for the piecewise-linear exp unit in the softmax datapath. It buffers one row of Q5.26 scores from an upstream stream and tracks the row maximum while loading. It then drives the exp unit's start/busy/done handshake once per element with max-subtracted arguments, accumulates the sum of the exp results, and streams the exp values downstream together with the row sum for the normaliser.

## Interface
Parameters:
- `Q`, 26, fractional bits of all data words (Q5.26).
- `W`, 32, data word width.
- `DEPTH`, 64, maximum row length; power of two.
- `SUM_W`, `W+$clog2(DEPTH)`, sum accumulator width (unsigned).
- `EXP_TIMEOUT`, 500, cycles allowed from `exp_start` to `exp_done`.

Ports:
- `clk`, in, 1, single clock; all logic is on its rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `in_valid`, in, 1, input score valid.
- `in_ready`, out, 1, sequencer accepts an input score.
- `in_data`, in, W, signed Q5.26 score.
- `in_last`, in, 1, marks the final score of the row.
- `exp_start`, out, 1, one-cycle request to the exp unit.
- `exp_x_q`, out, W, signed exp argument; held stable from `exp_start` until `exp_done`.
- `exp_busy`, in, 1, exp unit busy.
- `exp_done`, in, 1, one-cycle result strobe.
- `exp_y_q`, in, W, signed exp result; valid while `exp_done` is high.
- `out_valid`, out, 1, exp value valid.
- `out_ready`, in, 1, downstream accepts.
- `out_data`, out, W, exp value (Q5.26, always ≥ 0).
- `out_last`, out, 1, final element of the row.
- `sum_q`, out, SUM_W, row sum of exp values (Q26 fraction).
- `sum_valid`, out, 1, `sum_q` is final for the current row.
- `err_timeout`, out, 1, sticky: the exp unit timed out.
- `err_ovf`, out, 1, sticky: a row exceeded `DEPTH`.

## Operation
- States: LOAD, DRAIN, ISSUE, WAIT, STREAM.
- **LOAD:** `in_ready`=1.
  - Each handshake writes `buf[cnt]`, increments `cnt`, and updates `max`. The first element loads `max` unconditionally; later elements replace it when `in_data > max` (signed compare).
  - `in_last` → ISSUE with `idx`=0.
  - If the DEPTH-th beat arrives without `in_last`, it is treated as last and `err_ovf` is set. The next state is DRAIN if `in_last` is 0, otherwise ISSUE.
- **DRAIN:** `in_ready`=1. Beats are accepted and discarded until `in_last` is accepted, then → ISSUE.
- **ISSUE:**
  - Skipped if `exp_busy`=1; the sequencer waits in ISSUE until `exp_busy`=0.
  - Otherwise `exp_start`=1 for exactly one cycle, with `exp_x_q` = `buf[idx] - max`. The subtraction is done in W+1 bits and saturated to `-2^(W-1)`.
  - Next state → WAIT, and the timeout counter is cleared.
- **WAIT:**
  - On `exp_done`: `y` = (`exp_y_q` < 0) ? 0 : `exp_y_q`. Write `buf[idx]`=`y`, and add `y` (zero-extended) to `sum`.
  - Then `idx`++. If `idx` was `cnt-1` → STREAM, else → ISSUE.
  - If `EXP_TIMEOUT` cycles elapse without `exp_done`: set `err_timeout`, store 0, add 0, and advance as on done.
  - An `exp_done` received outside WAIT is ignored.
- **STREAM:**
  - `out_valid`=1 with `out_data`=`buf[ridx]`; `out_last`=1 when `ridx`=`cnt-1`.
  - `sum_valid`=1 and `sum_q` is held constant throughout STREAM.
  - On `out_valid` & `out_ready`, `ridx`++. The last handshake clears `cnt`, `sum` and `max` → LOAD.
- **Sum width:** `SUM_W` always holds `DEPTH` × max positive W-bit value, so the sum needs no saturation.
- **Error flags:** cleared only by reset.

## Timing
- **Reset values:** state=LOAD. All counters and `sum` are 0. `in_ready`=0 during reset, then 1 in the first cycle after release. All other outputs are 0 during reset; `exp_x_q`=0.
- **Load to first start:** the `in_last` handshake is in cycle N; `exp_start` rises in cycle N+1 if the exp unit is idle.
- **Per-element cost:** exp latency + 1 cycle. The next `exp_start` is asserted in the cycle after `exp_done`; no back-to-back start in the same cycle as done.
- **Buffer read:** `out_data` comes from registered buffer read. The first `out_valid` is asserted 1 cycle after entering STREAM; zero bubbles under continuous `out_ready`.
- **Output hold:** `out_data`/`out_last` are stable while `out_valid` & !`out_ready`.
- **Input/output exclusivity:** `in_ready` is 0 in ISSUE, WAIT and STREAM; no overlap of input and output rows.

## Configuration
- `SOFTMAX_MAX_SUB_EN` defined: max tracking is active and `exp_x_q` = `buf[idx] - max` (saturating).
- `SOFTMAX_MAX_SUB_EN` undefined: the max register and comparator are removed and `exp_x_q` = `buf[idx]` unmodified. All other behaviour and timing are identical.

## Test plan
Benches use a behavioural exp responder with programmable latency L that returns the exact Q5.26 `exp(x)`.
- **Max subtraction:** with the macro on, send row {0x04000000, 0x08000000, 0x08000000 (last)}, L=5 → `exp_x_q` sequence 0xFC000000, 0x0, 0x0. Out ≈ {0x0178B56D, 0x04000000, 0x04000000}, `sum_q` ≈ 0x0978B56D, `out_last` on the 3rd beat.
- **Macro off:** the same row → `exp_x_q` sequence 0x04000000, 0x08000000, 0x08000000.
- **Overflow:** DEPTH+3 beats with `in_last` on the final beat → `err_ovf`=1, exactly DEPTH starts, DEPTH outputs, the 3 extra beats are accepted and dropped.
- **Timeout:** the responder never asserts done on element 1 of a 4-row → `err_timeout`=1 after 500 cycles, `out_data[1]`=0, and the remaining 3 elements complete normally.
- **Backpressure:** `out_ready` toggles every other cycle → no lost or duplicated beats, and `sum_valid`/`sum_q` are stable across STREAM.
- **Reset and negative results:** assert `rst_n`=0 during WAIT → all outputs are 0 immediately, and a subsequent row completes correctly. A responder returning 0xFFFFFFF0 → stored and summed as 0.
